// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the boot-time instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned IM_ADDR_W_DEF  = 16;
  localparam int unsigned IM_DEPTH_DEF   = 1024;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned PHASE_W        = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_e;

endpackage

// File: rtl/word_pack.sv
// Assembles four stream bytes, MSB first, into one big-endian 32-bit word.
module word_pack
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_done_o,
  output logic [31:0] word_o
);

  logic [PHASE_W-1:0] phase_q;
  // The fourth byte is taken straight from the input, so only three are stored.
  logic [23:0]        shift_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      shift_q <= '0;
    end else if (byte_valid_i) begin
      phase_q <= phase_q + PHASE_W'(1);
      shift_q <= {shift_q[15:0], byte_i};
    end
  end

  assign word_done_o = byte_valid_i && (phase_q == PHASE_W'(BYTES_PER_WORD - 1));
  assign word_o      = {shift_q, byte_i};

endmodule

// File: rtl/imem_loader.sv
// Byte-stream boot loader: writes N words into instruction memory, verifies
// an XOR checksum and only then releases the core from reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned IM_ADDR_W = IM_ADDR_W_DEF,
  parameter int unsigned IM_DEPTH  = IM_DEPTH_DEF
) (
  input  logic                 CLK,
  input  logic                 RST_F,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 im_we,
  output logic [IM_ADDR_W-1:0] im_waddr,
  output logic [31:0]          im_wdata,
  output logic                 core_rst_f,
  output logic                 load_done,
  output logic                 load_err
);

  // One extra bit so a count of exactly 2^IM_ADDR_W words is representable.
  localparam int unsigned IDX_W = IM_ADDR_W + 1;

  state_e               state_q;
  logic [15:0]          cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [7:0]           csum_q;
  logic                 byte_ready_q;
  logic                 im_we_q;
  logic [IM_ADDR_W-1:0] im_waddr_q;
  logic [31:0]          im_wdata_q;
  logic                 core_rst_f_q;
  logic                 load_done_q;
  logic                 load_err_q;

  logic                 fire;
  logic                 data_fire;
  logic                 word_done;
  logic [31:0]          word;
  logic [15:0]          hdr_cnt;
  logic [IDX_W-1:0]     idx_inc;

  assign fire      = byte_valid && byte_ready_q;
  assign data_fire = fire && (state_q == S_DATA);
  assign hdr_cnt   = {cnt_q[15:8], byte_in};
  assign idx_inc   = idx_q + IDX_W'(1);

  word_pack u_word_pack (
    .clk          (CLK),
    .rst_n        (RST_F),
    .byte_valid_i (data_fire),
    .byte_i       (byte_in),
    .word_done_o  (word_done),
    .word_o       (word)
  );

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      state_q      <= S_CNT_HI;
      cnt_q        <= '0;
      idx_q        <= '0;
      csum_q       <= '0;
      byte_ready_q <= 1'b1;
      im_we_q      <= 1'b0;
      im_waddr_q   <= '0;
      im_wdata_q   <= '0;
      core_rst_f_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      im_we_q <= 1'b0;
      case (state_q)
        S_CNT_HI: if (fire) begin
          cnt_q[15:8] <= byte_in;
          state_q     <= S_CNT_LO;
        end
        S_CNT_LO: if (fire) begin
          cnt_q[7:0] <= byte_in;
          if (32'(hdr_cnt) > IM_DEPTH) begin
            state_q      <= S_ERR;
            byte_ready_q <= 1'b0;
            load_err_q   <= 1'b1;
          end else if (hdr_cnt == 16'd0) begin
            state_q <= S_CSUM;
          end else begin
            state_q <= S_DATA;
          end
        end
        S_DATA: if (fire) begin
          csum_q <= csum_q ^ byte_in;
          if (word_done) begin
            im_we_q    <= 1'b1;
            im_waddr_q <= idx_q[IM_ADDR_W-1:0];
            im_wdata_q <= word;
            idx_q      <= idx_inc;
            if (idx_inc == IDX_W'(cnt_q)) state_q <= S_CSUM;
          end
        end
        S_CSUM: if (fire) begin
          byte_ready_q <= 1'b0;
          if (byte_in == csum_q) begin
            state_q      <= S_RUN;
            core_rst_f_q <= 1'b1;
            load_done_q  <= 1'b1;
          end else begin
            state_q    <= S_ERR;
            load_err_q <= 1'b1;
          end
        end
        default: ; // S_RUN and S_ERR hold until reset
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign im_we      = im_we_q;
  assign im_waddr   = im_waddr_q;
  assign im_wdata   = im_wdata_q;
  assign core_rst_f = core_rst_f_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule
